// File: rtl/uart_buffered.sv
// uart_buffered: full-duplex UART with FIFO-buffered TX and RX paths.
// Frame: start, 7/8 data bits LSB first, optional parity, one stop bit.
//
// Ports:
//   CLK, RESET        clock, asynchronous active-high reset
//   BAUD_DIV          clock cycles per bit (values below 4 act as 4)
//   EIGHT, PEN, OHEL  8-bit data, parity enable, odd parity
//   RX / TX           serial input (asynchronous) / output (registered)
//   WR_DATA, WRITE    byte pushed into the TX FIFO
//   READ, RD_DATA     pop / first-word-fall-through head of the RX FIFO
//   CLR_ERR           clears sticky PERR, FERR, OVF, TOVF
//   STATUS            {TOVF, TX_EMPTY, RX_FULL, OVF, FERR, PERR, TXRDY, RXRDY}
//   IRQ               RXRDY | PERR | FERR | OVF | TOVF
module uart_buffered #(
    parameter int FIFO_AW = 4,
    parameter int DIV_W   = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [DIV_W-1:0] BAUD_DIV,
    input  logic             EIGHT,
    input  logic             PEN,
    input  logic             OHEL,
    input  logic             RX,
    output logic             TX,
    input  logic [7:0]       WR_DATA,
    input  logic             WRITE,
    input  logic             READ,
    input  logic             CLR_ERR,
    output logic [7:0]       RD_DATA,
    output logic [7:0]       STATUS,
    output logic             IRQ
);

    localparam int DEPTH = 2 ** FIFO_AW;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    localparam logic [FIFO_AW:0] PTR_ONE = 1;
    localparam logic [DIV_W-1:0] DIV_ONE = 1;
    localparam logic [DIV_W-1:0] DIV_MIN = 4;

    function automatic logic par_of(input logic [7:0] d,
                                    input logic       eight,
                                    input logic       odd);
        return (^{d[7] & eight, d[6:0]}) ^ odd;
    endfunction

    logic [DIV_W-1:0] div_in;
    assign div_in = (BAUD_DIV < DIV_MIN) ? DIV_MIN : BAUD_DIV;

    // ---------------- TX FIFO ----------------
    logic [7:0]       tx_mem [DEPTH];
    logic [FIFO_AW:0] tx_wp, tx_rp;
    logic             tx_fempty, tx_ffull, tx_push, tx_pop;
    logic [7:0]       tx_head;

    assign tx_fempty = (tx_wp == tx_rp);
    assign tx_ffull  = (tx_wp[FIFO_AW] != tx_rp[FIFO_AW]) &&
                       (tx_wp[FIFO_AW-1:0] == tx_rp[FIFO_AW-1:0]);
    // A write into a full FIFO still lands if the FSM frees a slot now.
    assign tx_push   = WRITE && (!tx_ffull || tx_pop);
    assign tx_head   = tx_mem[tx_rp[FIFO_AW-1:0]];

    always_ff @(posedge CLK) begin
        if (tx_push) tx_mem[tx_wp[FIFO_AW-1:0]] <= WR_DATA;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            tx_wp <= '0;
            tx_rp <= '0;
        end else begin
            if (tx_push) tx_wp <= tx_wp + PTR_ONE;
            if (tx_pop)  tx_rp <= tx_rp + PTR_ONE;
        end
    end

    // ---------------- TX FSM ----------------
    logic [2:0]       tx_st;
    logic [DIV_W-1:0] tx_div, tx_cnt;
    logic [2:0]       tx_idx;
    logic [7:0]       tx_sh;
    logic             tx_eight, tx_pen, tx_par, tx_q, tx_line, tx_bit_end;

    assign tx_bit_end = (tx_cnt == tx_div - DIV_ONE);
    // Pop when idle, or at the end of a stop bit so frames run back to back.
    assign tx_pop = !tx_fempty &&
                    ((tx_st == S_IDLE) || ((tx_st == S_STOP) && tx_bit_end));

    always_comb begin
        tx_line = 1'b1;
        case (tx_st)
            S_START:  tx_line = 1'b0;
            S_DATA:   tx_line = tx_sh[0];
            S_PARITY: tx_line = tx_par;
            default:  tx_line = 1'b1;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            tx_st    <= S_IDLE;
            tx_div   <= DIV_MIN;
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_sh    <= '0;
            tx_eight <= 1'b0;
            tx_pen   <= 1'b0;
            tx_par   <= 1'b0;
            tx_q     <= 1'b1;
        end else begin
            // Line is the state decode delayed one cycle: TX falls two
            // edges after the WRITE edge.
            tx_q <= tx_line;
            if (tx_pop) begin
                tx_st    <= S_START;
                tx_cnt   <= '0;
                tx_idx   <= '0;
                tx_div   <= div_in;
                tx_eight <= EIGHT;
                tx_pen   <= PEN;
                tx_sh    <= tx_head;
                tx_par   <= par_of(tx_head, EIGHT, OHEL);
            end else if (tx_st != S_IDLE) begin
                if (!tx_bit_end) begin
                    tx_cnt <= tx_cnt + DIV_ONE;
                end else begin
                    tx_cnt <= '0;
                    case (tx_st)
                        S_START: tx_st <= S_DATA;
                        S_DATA: begin
                            tx_sh  <= tx_sh >> 1;
                            tx_idx <= tx_idx + 3'd1;
                            if (tx_idx == (tx_eight ? 3'd7 : 3'd6))
                                tx_st <= tx_pen ? S_PARITY : S_STOP;
                        end
                        S_PARITY: tx_st <= S_STOP;
                        default:  tx_st <= S_IDLE;
                    endcase
                end
            end
        end
    end

    assign TX = tx_q;

    // ---------------- RX synchroniser ----------------
    // Reset to 0 so a line held low through reset shows no falling edge
    // until it has been seen high first.
    logic rx_m, rx_s, rx_prev, rx_fall;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            rx_m    <= 1'b0;
            rx_s    <= 1'b0;
            rx_prev <= 1'b0;
        end else begin
            rx_m    <= RX;
            rx_s    <= rx_m;
            rx_prev <= rx_s;
        end
    end

    assign rx_fall = rx_prev && !rx_s;

    // ---------------- RX FSM ----------------
    logic [2:0]       rx_st;
    logic [DIV_W-1:0] rx_div, rx_cnt;
    logic [2:0]       rx_idx;
    logic [7:0]       rx_sh;
    logic             rx_eight, rx_pen, rx_ohel, rx_pbit;
    logic             rx_bit_end, rx_mid, rx_push;
    logic             perr_set, ferr_set;

    assign rx_bit_end = (rx_cnt == rx_div - DIV_ONE);
    assign rx_mid     = (rx_cnt == (rx_div >> 1));
    assign rx_push    = (rx_st == S_STOP) && rx_bit_end;
    assign perr_set   = rx_push && rx_pen &&
                        (rx_pbit != ((^rx_sh) ^ rx_ohel));
    assign ferr_set   = rx_push && !rx_s;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            rx_st    <= S_IDLE;
            rx_div   <= DIV_MIN;
            rx_cnt   <= '0;
            rx_idx   <= '0;
            rx_sh    <= '0;
            rx_eight <= 1'b0;
            rx_pen   <= 1'b0;
            rx_ohel  <= 1'b0;
            rx_pbit  <= 1'b0;
        end else begin
            case (rx_st)
                S_IDLE: begin
                    if (rx_fall) begin
                        rx_st    <= S_START;
                        rx_cnt   <= '0;
                        rx_idx   <= '0;
                        rx_sh    <= '0;
                        rx_div   <= div_in;
                        rx_eight <= EIGHT;
                        rx_pen   <= PEN;
                        rx_ohel  <= OHEL;
                    end
                end
                S_START: begin
                    if (rx_mid) begin
                        rx_cnt <= '0;
                        rx_st  <= rx_s ? S_IDLE : S_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + DIV_ONE;
                    end
                end
                default: begin
                    if (!rx_bit_end) begin
                        rx_cnt <= rx_cnt + DIV_ONE;
                    end else begin
                        rx_cnt <= '0;
                        case (rx_st)
                            S_DATA: begin
                                rx_sh[rx_idx] <= rx_s;
                                rx_idx        <= rx_idx + 3'd1;
                                if (rx_idx == (rx_eight ? 3'd7 : 3'd6))
                                    rx_st <= rx_pen ? S_PARITY : S_STOP;
                            end
                            S_PARITY: begin
                                rx_pbit <= rx_s;
                                rx_st   <= S_STOP;
                            end
                            default: rx_st <= S_IDLE;
                        endcase
                    end
                end
            endcase
        end
    end

    // ---------------- RX FIFO ----------------
    logic [7:0]       rx_mem [DEPTH];
    logic [FIFO_AW:0] rx_wp, rx_rp;
    logic             rx_fempty, rx_ffull, rx_pop, rx_acc;
    logic [7:0]       rx_last;

    assign rx_fempty = (rx_wp == rx_rp);
    assign rx_ffull  = (rx_wp[FIFO_AW] != rx_rp[FIFO_AW]) &&
                       (rx_wp[FIFO_AW-1:0] == rx_rp[FIFO_AW-1:0]);
    assign rx_pop    = READ && !rx_fempty;
    assign rx_acc    = rx_push && (!rx_ffull || rx_pop);

    always_ff @(posedge CLK) begin
        if (rx_acc) rx_mem[rx_wp[FIFO_AW-1:0]] <= rx_sh;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            rx_wp   <= '0;
            rx_rp   <= '0;
            rx_last <= '0;
        end else begin
            if (rx_acc) rx_wp <= rx_wp + PTR_ONE;
            if (rx_pop) begin
                rx_rp   <= rx_rp + PTR_ONE;
                rx_last <= rx_mem[rx_rp[FIFO_AW-1:0]];
            end
        end
    end

    // Empty FIFO keeps showing the byte most recently popped.
    assign RD_DATA = rx_fempty ? rx_last : rx_mem[rx_rp[FIFO_AW-1:0]];

    // ---------------- Sticky flags ----------------
    logic perr, ferr, ovf, tovf;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            perr <= 1'b0;
            ferr <= 1'b0;
            ovf  <= 1'b0;
            tovf <= 1'b0;
        end else begin
            // A set event beats a simultaneous clear.
            perr <= perr_set | (perr & ~CLR_ERR);
            ferr <= ferr_set | (ferr & ~CLR_ERR);
            ovf  <= (rx_push && rx_ffull && !rx_pop) | (ovf & ~CLR_ERR);
            tovf <= (WRITE && tx_ffull && !tx_pop) | (tovf & ~CLR_ERR);
        end
    end

    logic tx_empty;
    assign tx_empty = tx_fempty && (tx_st == S_IDLE);

    assign STATUS = {tovf, tx_empty, rx_ffull, ovf,
                     ferr, perr, !tx_ffull, !rx_fempty};
    assign IRQ    = !rx_fempty | perr | ferr | ovf | tovf;

endmodule

// File: tb/tb_uart_buffered.sv
// tb_uart_buffered: directed bench for uart_buffered with a cycle-level
// model of the TX line and a scoreboard of received bytes.
module tb_uart_buffered;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] baud_div = 16'd16;
    logic        eight = 1'b1;
    logic        pen = 1'b1;
    logic        ohel = 1'b0;
    logic        rx_drv = 1'b1;
    logic        loop_en = 1'b0;
    logic        rx_line;
    logic        tx;
    logic [7:0]  wr_data = 8'h00;
    logic        write = 1'b0;
    logic        read = 1'b0;
    logic        clr_err = 1'b0;
    logic [7:0]  rd_data;
    logic [7:0]  status;
    logic        irq;

    int checks = 0;
    int errors = 0;

    logic       txq[$];
    logic [7:0] exp_rx[$];
    logic [7:0] last_rd;
    int         a5_bits[11] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 1};

    assign rx_line = loop_en ? tx : rx_drv;

    always #5 clk = ~clk;

    uart_buffered #(.FIFO_AW(4), .DIV_W(16)) dut (
        .CLK(clk), .RESET(rst), .BAUD_DIV(baud_div),
        .EIGHT(eight), .PEN(pen), .OHEL(ohel),
        .RX(rx_line), .TX(tx),
        .WR_DATA(wr_data), .WRITE(write), .READ(read),
        .CLR_ERR(clr_err), .RD_DATA(rd_data),
        .STATUS(status), .IRQ(irq)
    );

    function automatic void check(input string nm,
                                  input logic [31:0] act,
                                  input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endfunction

    function automatic logic ref_par(input logic [7:0] d, input int nb,
                                     input logic odd);
        int ones = 0;
        for (int i = 0; i < nb; i++) ones += int'(d[i]);
        return ((ones % 2) == 1) ^ odd;
    endfunction

    // Expected TX level after each coming rising edge.  A frame begins no
    // sooner than two edges after its WRITE and no sooner than the end of
    // the frame already queued.
    function automatic void model_write(input logic [7:0] b);
        int d  = (baud_div < 16'd4) ? 4 : int'(baud_div);
        int nb = eight ? 8 : 7;
        while (txq.size() < 2) txq.push_back(1'b1);
        repeat (d) txq.push_back(1'b0);
        for (int i = 0; i < nb; i++) repeat (d) txq.push_back(b[i]);
        if (pen) repeat (d) txq.push_back(ref_par(b, nb, ohel));
        repeat (d) txq.push_back(1'b1);
    endfunction

    always @(negedge clk) begin : cmp
        logic e;
        if (!rst) begin
            e = (txq.size() > 0) ? txq.pop_front() : 1'b1;
            check("tx_line", 32'(tx), 32'(e));
        end
    end

    task automatic wr_byte(input logic [7:0] b, input logic acc);
        write   = 1'b1;
        wr_data = b;
        @(posedge clk);
        if (acc) model_write(b);
        @(negedge clk);
        write = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
    endtask

    task automatic read_chk(input string nm, input logic [7:0] exp);
        check({nm, "_rdy"}, 32'(status[0]), 1);
        check(nm, 32'(rd_data), 32'(exp));
        read = 1'b1;
        @(negedge clk);
        read = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] d, input int nb,
                              input logic usep, input logic pbit,
                              input logic stopb, input int div);
        rx_drv = 1'b0;
        repeat (div) @(negedge clk);
        for (int i = 0; i < nb; i++) begin
            rx_drv = d[i];
            repeat (div) @(negedge clk);
        end
        if (usep) begin
            rx_drv = pbit;
            repeat (div) @(negedge clk);
        end
        rx_drv = stopb;
        repeat (div) @(negedge clk);
        rx_drv = 1'b1;
        repeat (div) @(negedge clk);
    endtask

    task automatic wait_tx_idle(input int budget);
        int n = 0;
        while (status[6] !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("tx_drain", 32'(n < budget), 1);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [7:0] b;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_status", 32'(status), 32'h42);
        check("rst_tx", 32'(tx), 1);
        check("rst_rd", 32'(rd_data), 0);
        check("rst_irq", 32'(irq), 0);
        #2 rst = 1'b0;
        @(negedge clk);

        // A5 at 16 cycles/bit, even parity; config change mid-frame
        wr_byte(8'hA5, 1'b1);
        @(negedge clk);
        check("a5_e1", 32'(tx), 1);
        @(negedge clk);
        check("a5_fall", 32'(tx), 0);
        repeat (8) @(negedge clk);
        check("a5_bit0", 32'(tx), 32'(a5_bits[0]));
        check("a5_busy", 32'(status[6]), 0);
        for (int k = 1; k < 11; k++) begin
            repeat (16) @(negedge clk);
            check($sformatf("a5_bit%0d", k), 32'(tx), 32'(a5_bits[k]));
            if (k == 3) begin
                baud_div = 16'd8;
                pen      = 1'b0;
                eight    = 1'b0;
            end
        end
        repeat (6) @(negedge clk);
        check("a5_stop_end", 32'(tx), 1);
        check("a5_notempty", 32'(status[6]), 0);
        @(negedge clk);
        check("a5_empty", 32'(status[6]), 1);
        baud_div = 16'd16;
        pen      = 1'b1;
        eight    = 1'b1;
        repeat (4) @(negedge clk);

        // Loopback of 16 back-to-back bytes
        loop_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            b = 8'(i * 37 + 5);
            exp_rx.push_back(b);
            wr_byte(b, 1'b1);
        end
        wait_tx_idle(4000);
        repeat (20) @(negedge clk);
        check("loop_status", 32'(status), 32'h63);
        loop_en = 1'b0;

        // 17th byte into a full RX FIFO
        send_frame(8'hE7, 8, 1'b1, ref_par(8'hE7, 8, 1'b0), 1'b1, 16);
        check("ovf_status", 32'(status), 32'h73);
        check("ovf_irq", 32'(irq), 1);
        for (int i = 0; i < 16; i++) begin
            last_rd = exp_rx.pop_front();
            read_chk($sformatf("loop_rd%0d", i), last_rd);
        end
        check("ovf_drained", 32'(status), 32'h52);
        pulse_clr();
        check("ovf_cleared", 32'(status), 32'h42);
        check("ovf_irq_clr", 32'(irq), 0);
        read = 1'b1;
        @(negedge clk);
        read = 1'b0;
        check("empty_read_hold", 32'(rd_data), 32'(last_rd));
        check("empty_read_st", 32'(status), 32'h42);

        // 7-bit frame, bad parity and stop = 0
        eight = 1'b0;
        send_frame(8'h3C, 7, 1'b1, ~ref_par(8'h3C, 7, 1'b0), 1'b0, 16);
        check("err_status", 32'(status), 32'h4F);
        read_chk("err_rd", 8'h3C);
        pulse_clr();
        check("err_cleared", 32'(status), 32'h42);

        // 7-bit odd parity, bit 7 not received
        ohel = 1'b1;
        send_frame(8'hFF, 7, 1'b1, ref_par(8'hFF, 7, 1'b1), 1'b1, 16);
        check("odd7_status", 32'(status), 32'h43);
        read_chk("odd7_rd", 8'h7F);

        // 8-bit, no parity
        eight = 1'b1;
        pen   = 1'b0;
        send_frame(8'h81, 8, 1'b0, 1'b0, 1'b1, 16);
        check("np8_status", 32'(status), 32'h43);
        read_chk("np8_rd", 8'h81);

        // False start: 6-cycle low pulse
        rx_drv = 1'b0;
        repeat (6) @(negedge clk);
        rx_drv = 1'b1;
        repeat (40) @(negedge clk);
        check("glitch_status", 32'(status), 32'h42);

        // Reset during an RX frame while the line is low
        rx_drv = 1'b0;
        repeat (20) @(negedge clk);
        #2 rst = 1'b1;
        txq.delete();
        @(negedge clk);
        #2 rst = 1'b0;
        repeat (300) @(negedge clk);
        check("low_ignored", 32'(status), 32'h42);
        rx_drv = 1'b1;
        repeat (40) @(negedge clk);
        check("low_release", 32'(status), 32'h42);
        send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1, 16);
        read_chk("after_rst_rd", 8'h5A);

        // BAUD_DIV=2 acts as 4; 18th write into full TX FIFO with CLR_ERR
        baud_div = 16'd2;
        pen      = 1'b1;
        ohel     = 1'b1;
        for (int i = 0; i < 17; i++) wr_byte(8'(i * 11 + 1), 1'b1);
        clr_err = 1'b1;
        wr_byte(8'hEE, 1'b0);
        clr_err = 1'b0;
        check("tovf_vs_clr", 32'(status[7]), 1);
        check("txrdy_full", 32'(status[1]), 0);
        check("tovf_irq", 32'(irq), 1);
        wait_tx_idle(2000);
        repeat (5) @(negedge clk);
        check("tovf_status", 32'(status), 32'hC2);
        pulse_clr();
        check("tovf_cleared", 32'(status), 32'h42);

        // Reset in the middle of a TX data bit
        baud_div = 16'd16;
        ohel     = 1'b0;
        eight    = 1'b1;
        wr_byte(8'hA5, 1'b1);
        repeat (60) @(negedge clk);
        #2 rst = 1'b1;
        txq.delete();
        #1;
        check("mid_rst_tx", 32'(tx), 1);
        check("mid_rst_status", 32'(status), 32'h42);
        check("mid_rst_rd", 32'(rd_data), 0);
        check("mid_rst_irq", 32'(irq), 0);
        @(negedge clk);
        #2 rst = 1'b0;
        repeat (40) @(negedge clk);
        check("post_rst_tx", 32'(tx), 1);
        check("post_rst_status", 32'(status), 32'h42);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
